// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan counter.
// The BCD successor helper keeps the wrap-at-nine rule in one place.
package seg_pkg;

   localparam int          NDIG     = 4;
   localparam logic [3:0]  BCD_MAX  = 4'd9;
   localparam logic [3:0]  AN_RESET = 4'b1110;

   typedef logic [3:0] bcd_t;

   function automatic bcd_t bcd_next(input bcd_t d);
      if (d == BCD_MAX) begin
         return 4'd0;
      end else begin
         return d + 4'd1;
      end
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: increments on INC, clears on CLR (CLR wins).
// CO is combinational so a chain of digits ripples within one cycle.
module bcd_digit
   import seg_pkg::*;
(
   input  logic CLK,
   input  logic RST_N,
   input  logic CLR,
   input  logic INC,
   output bcd_t Q,
   output logic CO
);

   bcd_t q_q;
   bcd_t q_d;

   // Next digit value
   always_comb begin
      q_d = q_q;
      if (CLR) begin
         q_d = 4'd0;
      end else if (INC) begin
         q_d = bcd_next(q_q);
      end else begin
         q_d = q_q;
      end
   end

   // Digit register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         q_q <= 4'd0;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q  = q_q;
   assign CO = INC && (q_q == BCD_MAX);

endmodule

// File: rtl/seg_scan_counter.sv
// Free-running 4-digit BCD counter with a time-multiplexed digit bus
// and one-cold active-low digit selects for a common-anode display.
module seg_scan_counter
   import seg_pkg::*;
#(
   parameter int TICK_DIV   = 50000,
   parameter int STEP_TICKS = 1000
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                EN,
   input  logic                CLR,
   output logic [3:0]          CODE,
   output logic [NDIG-1:0]     AN,
   output logic [4*NDIG-1:0]   COUNT,
   output logic                CARRY
);

   localparam int PW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int SW     = (STEP_TICKS > 2) ? $clog2(STEP_TICKS) : 1;
   localparam int SCAN_W = $clog2(NDIG);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_TICKS - 1);
   localparam logic [NDIG-1:0] AN_ONE   = NDIG'(1);

   logic [PW-1:0]     presc_q, presc_d;
   logic [SCAN_W-1:0] scan_q,  scan_d;
   logic [SW-1:0]     step_q,  step_d;
   logic [3:0]        code_q,  code_d;
   logic [NDIG-1:0]   an_q,    an_d;
   logic              carry_q, carry_d;
   logic              tick_s;
   logic              step_s;
   logic [4*NDIG-1:0] count_s;

   // Prescaler, scan index and step counter next state
   always_comb begin
      tick_s  = (presc_q == PRESC_LAST);
      step_s  = 1'b0;
      step_d  = step_q;
      if (tick_s) begin
         presc_d = '0;
         scan_d  = scan_q + SCAN_W'(1);
      end else begin
         presc_d = presc_q + PW'(1);
         scan_d  = scan_q;
      end
      // CLR zeroes the step phase and swallows any step on the same cycle
      if (CLR) begin
         step_d = '0;
      end else if (EN && tick_s) begin
         if (step_q == STEP_LAST) begin
            step_d = '0;
            step_s = 1'b1;
         end else begin
            step_d = step_q + SW'(1);
         end
      end else begin
         step_d = step_q;
      end
   end

   for (genvar i = 0; i < NDIG; i++) begin : g_dig
      logic inc_l;
      logic co_l;
      bcd_t q_l;
      if (i == 0) begin : g_first
         assign inc_l = step_s;
      end else begin : g_rest
         assign inc_l = g_dig[i-1].co_l;
      end
      bcd_digit u_digit (
         .CLK   (CLK),
         .RST_N (RST_N),
         .CLR   (CLR),
         .INC   (inc_l),
         .Q     (q_l),
         .CO    (co_l)
      );
      assign count_s[4*i +: 4] = q_l;
   end

   // Output stage: selected nibble, digit select and wrap pulse
   always_comb begin
      carry_d = g_dig[NDIG-1].co_l;
      code_d  = count_s[{scan_q, 2'b00} +: 4];
      an_d    = ~(AN_ONE << scan_q);
   end

   // Control and output registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         presc_q <= '0;
         scan_q  <= '0;
         step_q  <= '0;
         code_q  <= 4'd0;
         an_q    <= AN_RESET;
         carry_q <= 1'b0;
      end else begin
         presc_q <= presc_d;
         scan_q  <= scan_d;
         step_q  <= step_d;
         code_q  <= code_d;
         an_q    <= an_d;
         carry_q <= carry_d;
      end
   end

   assign COUNT = count_s;
   assign CODE  = code_q;
   assign AN    = an_q;
   assign CARRY = carry_q;

endmodule

// File: tb/tb_seg_scan_counter.sv
// Directed bench for seg_scan_counter with TICK_DIV=4, STEP_TICKS=2.
// A small integer model tracks edges; key points are also hand-checked.
module tb_seg_scan_counter;

   localparam int TD = 4;
   localparam int ST = 2;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        EN;
   logic        CLR;
   logic [3:0]  CODE;
   logic [3:0]  AN;
   logic [15:0] COUNT;
   logic        CARRY;

   int total = 0;
   int bad   = 0;

   int         presc_m, scan_m, step_m, cnt_m, edge_k;
   logic       carry_m;
   logic [3:0] code_m, an_m;

   always #5 CLK = ~CLK;

   seg_scan_counter #(.TICK_DIV(TD), .STEP_TICKS(ST)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .EN    (EN),
      .CLR   (CLR),
      .CODE  (CODE),
      .AN    (AN),
      .COUNT (COUNT),
      .CARRY (CARRY)
   );

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int t;
      t = v;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic model_reset;
      presc_m = 0; scan_m = 0; step_m = 0; cnt_m = 0; edge_k = 0;
      carry_m = 1'b0; code_m = 4'd0; an_m = 4'b1110;
   endtask

   // Advance the model by one rising edge using the inputs seen before it.
   task automatic model_edge;
      logic        tick;
      logic [15:0] b;
      tick   = (presc_m == TD - 1);
      b      = to_bcd(cnt_m);
      code_m = b[scan_m*4 +: 4];
      an_m   = ~(4'b0001 << scan_m);
      presc_m = tick ? 0 : presc_m + 1;
      carry_m = 1'b0;
      if (CLR) begin
         cnt_m = 0; step_m = 0;
      end else if (EN && tick) begin
         if (step_m == ST - 1) begin
            step_m = 0;
            if (cnt_m == 9999) begin cnt_m = 0; carry_m = 1'b1; end
            else cnt_m = cnt_m + 1;
         end else begin
            step_m = step_m + 1;
         end
      end
      if (tick) scan_m = (scan_m + 1) % 4;
      edge_k = edge_k + 1;
   endtask

   task automatic do_reset;
      @(negedge CLK);
      RST_N = 1'b0; EN = 1'b0; CLR = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      model_reset();
   endtask

   task automatic test_reset;
      @(negedge CLK);
      RST_N = 1'b0; EN = 1'b0; CLR = 1'b0;
      repeat (2) @(negedge CLK);
      total++;
      if ({AN, CODE, COUNT, CARRY} !== {4'b1110, 4'd0, 16'h0000, 1'b0}) begin
         bad++;
         $display("FAIL reset_during: got an=%b code=%h count=%h carry=%b", AN, CODE, COUNT, CARRY);
      end
      RST_N = 1'b1;
      model_reset();
      repeat (3) begin
         @(posedge CLK); model_edge(); @(negedge CLK);
         total++;
         if ({AN, CODE, COUNT, CARRY} !== {4'b1110, 4'd0, 16'h0000, 1'b0}) begin
            bad++;
            $display("FAIL reset_after k=%0d: got an=%b code=%h count=%h carry=%b", edge_k, AN, CODE, COUNT, CARRY);
         end
      end
   endtask

   task automatic test_scan;
      logic [3:0] exp_an;
      do_reset();
      EN = 1'b0;
      repeat (20) begin
         @(posedge CLK); model_edge(); @(negedge CLK);
         total++;
         if ({AN, CODE} !== {an_m, code_m}) begin
            bad++;
            $display("FAIL scan k=%0d: got an=%b code=%h want an=%b code=%h", edge_k, AN, CODE, an_m, code_m);
         end
         if (edge_k == 5 || edge_k == 9 || edge_k == 13 || edge_k == 17) begin
            case (edge_k)
               5:       exp_an = 4'b1101;
               9:       exp_an = 4'b1011;
               13:      exp_an = 4'b0111;
               default: exp_an = 4'b1110;
            endcase
            total++;
            if (AN !== exp_an) begin
               bad++;
               $display("FAIL scan_seq k=%0d: got %b want %b", edge_k, AN, exp_an);
            end
         end
      end
   endtask

   task automatic test_count;
      do_reset();
      EN = 1'b1;
      repeat (800) begin
         @(posedge CLK); model_edge(); @(negedge CLK);
         total++;
         if ({AN, CODE, COUNT, CARRY} !== {an_m, code_m, to_bcd(cnt_m), carry_m}) begin
            bad++;
            $display("FAIL count k=%0d: got %b/%h/%h/%b want %b/%h/%h/%b", edge_k,
                     AN, CODE, COUNT, CARRY, an_m, code_m, to_bcd(cnt_m), carry_m);
         end
         if (edge_k == 8 || edge_k == 80 || edge_k == 800) begin
            total++;
            if (COUNT !== ((edge_k == 8) ? 16'h0001 : (edge_k == 80) ? 16'h0010 : 16'h0100)) begin
               bad++;
               $display("FAIL count_mark k=%0d: got %h", edge_k, COUNT);
            end
         end
      end
   endtask

   task automatic test_wrap;
      int carries;
      carries = 0;
      do_reset();
      EN = 1'b1;
      repeat (80008) begin
         @(posedge CLK); model_edge(); @(negedge CLK);
         if (CARRY === 1'b1) carries++;
         total++;
         if ({AN, CODE, COUNT, CARRY} !== {an_m, code_m, to_bcd(cnt_m), carry_m}) begin
            bad++;
            $display("FAIL wrap k=%0d: got %b/%h/%h/%b want %b/%h/%h/%b", edge_k,
                     AN, CODE, COUNT, CARRY, an_m, code_m, to_bcd(cnt_m), carry_m);
         end
         if (edge_k == 79992) begin
            total++;
            if (COUNT !== 16'h9999) begin
               bad++;
               $display("FAIL wrap_9999: got %h want 9999", COUNT);
            end
         end
         if (edge_k == 80000) begin
            total++;
            if ({COUNT, CARRY} !== {16'h0000, 1'b1}) begin
               bad++;
               $display("FAIL wrap_zero: got count=%h carry=%b want 0000/1", COUNT, CARRY);
            end
         end
      end
      total++;
      if (carries !== 1) begin
         bad++;
         $display("FAIL wrap_carry_count: got %0d want 1", carries);
      end
   endtask

   task automatic test_clear;
      do_reset();
      EN = 1'b1;
      repeat (830) begin
         @(posedge CLK); model_edge(); @(negedge CLK);
         total++;
         if ({AN, CODE, COUNT, CARRY} !== {an_m, code_m, to_bcd(cnt_m), carry_m}) begin
            bad++;
            $display("FAIL clear k=%0d: got %b/%h/%h/%b want %b/%h/%h/%b", edge_k,
                     AN, CODE, COUNT, CARRY, an_m, code_m, to_bcd(cnt_m), carry_m);
         end
         if (edge_k == 799 || edge_k == 800 || edge_k == 811 || edge_k == 812) begin
            total++;
            if ({COUNT, CARRY} !== {((edge_k == 799) ? 16'h0099 : (edge_k == 812) ? 16'h0001 : 16'h0000), 1'b0}) begin
               bad++;
               $display("FAIL clear_mark k=%0d: got count=%h carry=%b", edge_k, COUNT, CARRY);
            end
         end
         CLR = (edge_k >= 799 && edge_k < 804);
      end
      CLR = 1'b0;
   endtask

   task automatic test_async_reset;
      do_reset();
      EN = 1'b1;
      repeat (984) begin
         @(posedge CLK); model_edge(); @(negedge CLK);
      end
      total++;
      if (COUNT !== 16'h0123) begin
         bad++;
         $display("FAIL async_pre: got %h want 0123", COUNT);
      end
      #2 RST_N = 1'b0;
      #1;
      total++;
      if ({AN, CODE, COUNT, CARRY} !== {4'b1110, 4'd0, 16'h0000, 1'b0}) begin
         bad++;
         $display("FAIL async_reset: got an=%b code=%h count=%h carry=%b", AN, CODE, COUNT, CARRY);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      EN = 1'b0;
   endtask

   initial begin
      RST_N = 1'b0; EN = 1'b0; CLR = 1'b0;
      model_reset();
      test_reset();
      test_scan();
      test_count();
      test_clear();
      test_async_reset();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
